indicator_lamp_scheduler: RTL and testbench

//  Sequences the left/right indicator lamps from the turn-signal state and a hazard request.

---
 rtl/vehicle_pkg.sv | 39 +++
 rtl/blink_timer.sv | 52 +++++
 rtl/indicator_lamp_scheduler.sv | 115 +++++++++++
 tb/tb_indicator_lamp_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vehicle_pkg.sv
// Shared vehicle-lamp types: turn-signal encodings, lamp-mode states and _mode output codes.
package vehicle_pkg;

    localparam logic [1:0] _NO_TURN_STATE    = 2'b00;
    localparam logic [1:0] _LEFT_TURN_STATE  = 2'b01;
    localparam logic [1:0] _RIGHT_TURN_STATE = 2'b11;

    localparam logic [1:0] _MODE_IDLE   = 2'b00;
    localparam logic [1:0] _MODE_LEFT   = 2'b01;
    localparam logic [1:0] _MODE_RIGHT  = 2'b11;
    localparam logic [1:0] _MODE_HAZARD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        TURN_L,
        TURN_R,
        HAZARD,
        COMFORT_L,
        COMFORT_R
    } lamp_mode_e;

    function automatic logic [1:0] mode_code(input lamp_mode_e s);
        case (s)
            TURN_L, COMFORT_L: mode_code = _MODE_LEFT;
            TURN_R, COMFORT_R: mode_code = _MODE_RIGHT;
            HAZARD:            mode_code = _MODE_HAZARD;
            default:           mode_code = _MODE_IDLE;
        endcase
    endfunction

    function automatic logic drives_left(input lamp_mode_e s);
        drives_left = (s == TURN_L) || (s == COMFORT_L) || (s == HAZARD);
    endfunction

    function automatic logic drives_right(input lamp_mode_e s);
        drives_right = (s == TURN_R) || (s == COMFORT_R) || (s == HAZARD);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink cadence generator: HALF_PERIOD cycles ON, HALF_PERIOD cycles OFF, restartable at ON.
// phase/on_edge present the values that take effect at the next clock edge.
module blink_timer #(
    parameter int unsigned HALF_PERIOD = 50
) (
    input  logic clock,
    input  logic _reset_n,
    input  logic restart,
    input  logic enable,
    output logic phase,
    output logic on_edge,
    output logic off_done
);

    localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q;

    always_comb begin
        cnt_d   = '0;
        phase   = 1'b0;
        on_edge = 1'b0;
        if (enable) begin
            if (restart) begin
                phase   = 1'b1;
                on_edge = 1'b1;
            end else if (cnt_q == LAST) begin
                phase   = ~phase_q;
                on_edge = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                phase = phase_q;
            end
        end
    end

    // Last cycle of an OFF phase; depends only on state so callers can steer on it.
    assign off_done = ~phase_q && (cnt_q == LAST);

    always_ff @(posedge clock) begin
        if (!_reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase;
        end
    end

endmodule

// File: rtl/indicator_lamp_scheduler.sv
// Indicator lamp FSM and lamp mux over a shared blink_timer; hazard outranks turn requests.
// Optional comfort blink (minimum flashes per turn request) enabled by INDICATOR_COMFORT_BLINK_EN.
module indicator_lamp_scheduler
    import vehicle_pkg::*;
#(
    parameter int unsigned HALF_PERIOD     = 50,
    parameter int unsigned COMFORT_FLASHES = 3
) (
    input  logic       clock,
    input  logic       _reset_n,
    input  logic       _switch,
    input  logic [1:0] _turnState,
    input  logic       _hazardReq,
    output logic       _leftLamp,
    output logic       _rightLamp,
    output logic       _tick,
    output logic [1:0] _mode
);

    if (HALF_PERIOD < 2 || COMFORT_FLASHES < 1 || COMFORT_FLASHES > 15) begin : gen_bad_param
        $error("indicator_lamp_scheduler: parameter out of range");
    end

    lamp_mode_e state_q, state_d, req;
    logic       restart, enable, phase, on_edge, off_done;

    always_comb begin
        if (_hazardReq) begin
            req = HAZARD;
        end else if (_switch && _turnState == _LEFT_TURN_STATE) begin
            req = TURN_L;
        end else if (_switch && _turnState == _RIGHT_TURN_STATE) begin
            req = TURN_R;
        end else begin
            req = IDLE;
        end
    end

`ifdef INDICATOR_COMFORT_BLINK_EN
    localparam logic [3:0] FLASH_TARGET = 4'(COMFORT_FLASHES);

    logic [3:0] flash_q, flash_d;

    always_comb begin
        state_d = req;
        if (req == IDLE && _switch) begin
            case (state_q)
                TURN_L:    state_d = (flash_q < FLASH_TARGET) ? COMFORT_L : IDLE;
                TURN_R:    state_d = (flash_q < FLASH_TARGET) ? COMFORT_R : IDLE;
                COMFORT_L: state_d = (off_done && flash_q >= FLASH_TARGET) ? IDLE : COMFORT_L;
                COMFORT_R: state_d = (off_done && flash_q >= FLASH_TARGET) ? IDLE : COMFORT_R;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Entry to TURN_x starts its first ON phase, so the count restarts at 1.
    always_comb begin
        flash_d = flash_q;
        if (!(state_d inside {TURN_L, TURN_R, COMFORT_L, COMFORT_R})) begin
            flash_d = '0;
        end else if (restart) begin
            flash_d = 4'd1;
        end else if (on_edge && flash_q != 4'hF) begin
            flash_d = flash_q + 4'd1;
        end
    end
`else
    logic unused_off_done;
    assign unused_off_done = off_done;

    always_comb begin
        state_d = req;
    end
`endif

    // Comfort states continue the running blink; every other active entry restarts it.
    assign restart = (state_d != state_q) && (state_d inside {TURN_L, TURN_R, HAZARD});
    assign enable  = (state_d != IDLE);

    blink_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_blink_timer (
        .clock   (clock),
        ._reset_n(_reset_n),
        .restart (restart),
        .enable  (enable),
        .phase   (phase),
        .on_edge (on_edge),
        .off_done(off_done)
    );

    always_ff @(posedge clock) begin
        if (!_reset_n) begin
            state_q    <= IDLE;
            _leftLamp  <= 1'b0;
            _rightLamp <= 1'b0;
            _tick      <= 1'b0;
            _mode      <= _MODE_IDLE;
`ifdef INDICATOR_COMFORT_BLINK_EN
            flash_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            _leftLamp  <= phase & drives_left(state_d);
            _rightLamp <= phase & drives_right(state_d);
            _tick      <= on_edge;
            _mode      <= mode_code(state_d);
`ifdef INDICATOR_COMFORT_BLINK_EN
            flash_q    <= flash_d;
`endif
        end
    end

endmodule

// File: tb/tb_indicator_lamp_scheduler.sv
// Directed bench for indicator_lamp_scheduler (HALF_PERIOD=4, COMFORT_FLASHES=3); observes
// {_mode,_tick,_rightLamp,_leftLamp} one time unit after each rising edge.
module tb_indicator_lamp_scheduler;

    logic       clock = 1'b0;
    logic       _reset_n;
    logic       _switch;
    logic [1:0] _turnState;
    logic       _hazardReq;
    logic       _leftLamp;
    logic       _rightLamp;
    logic       _tick;
    logic [1:0] _mode;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    indicator_lamp_scheduler #(
        .HALF_PERIOD    (4),
        .COMFORT_FLASHES(3)
    ) dut (
        .clock     (clock),
        ._reset_n  (_reset_n),
        ._switch   (_switch),
        ._turnState(_turnState),
        ._hazardReq(_hazardReq),
        ._leftLamp (_leftLamp),
        ._rightLamp(_rightLamp),
        ._tick     (_tick),
        ._mode     (_mode)
    );

    function automatic logic [4:0] vec(input logic [1:0] m, input logic t, input logic r,
                                       input logic l);
        vec = {m, t, r, l};
    endfunction

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got mode/tick/R/L=%b required=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] obs();
        obs = {_mode, _tick, _rightLamp, _leftLamp};
    endfunction

    initial begin
        logic on;
        logic tk;
        _reset_n   = 1'b0;
        _switch    = 1'b0;
        _turnState = 2'b00;
        _hazardReq = 1'b1;

        // 1. reset overrides a hazard request
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq($sformatf("reset_c%0d", c), obs(), vec(2'b00, 0, 0, 0));
        end
        _hazardReq = 1'b0;
        _reset_n   = 1'b1;
        step();
        check_eq("idle_after_reset", obs(), vec(2'b00, 0, 0, 0));

        // 2. left turn: ON 1-4, OFF 5-8, tick at 1 and 9
        _switch    = 1'b1;
        _turnState = 2'b01;
        for (int c = 1; c <= 9; c++) begin
            step();
            on = (c <= 4) || (c == 9);
            tk = (c == 1) || (c == 9);
            check_eq($sformatf("left_c%0d", c), obs(), vec(2'b01, tk, 0, on));
        end
        for (int c = 10; c <= 14; c++) begin
            step();
            check_eq($sformatf("left_c%0d", c), obs(), vec(2'b01, 0, 0, c <= 12));
        end

        // 3. hazard mid-OFF, then release back to left turn
        _hazardReq = 1'b1;
        step();
        check_eq("haz_preempt", obs(), vec(2'b10, 1, 1, 1));
        step();
        check_eq("haz_hold", obs(), vec(2'b10, 0, 1, 1));
        _hazardReq = 1'b0;
        step();
        check_eq("haz_release", obs(), vec(2'b01, 1, 0, 1));
        step();
        check_eq("left_resumed", obs(), vec(2'b01, 0, 0, 1));

        // 4. hazard with ignition off; right turn request ignored
        _switch    = 1'b0;
        _hazardReq = 1'b1;
        _turnState = 2'b11;
        for (int c = 1; c <= 9; c++) begin
            step();
            on = (c <= 4) || (c == 9);
            tk = (c == 1) || (c == 9);
            check_eq($sformatf("haz_c%0d", c), obs(), vec(2'b10, tk, on, on));
        end
        _hazardReq = 1'b0;
        step();
        check_eq("haz_off", obs(), vec(2'b00, 0, 0, 0));

        // 5. short right request: comfort flashes or immediate drop
        _switch    = 1'b1;
        _turnState = 2'b11;
        step();
        check_eq("right_c1", obs(), vec(2'b11, 1, 1, 0));
        step();
        check_eq("right_c2", obs(), vec(2'b11, 0, 1, 0));
        _turnState = 2'b00;
`ifdef INDICATOR_COMFORT_BLINK_EN
        for (int c = 3; c <= 25; c++) begin
            step();
            on = (c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20);
            tk = (c == 9) || (c == 17);
            check_eq($sformatf("comfort_c%0d", c), obs(),
                     vec((c <= 24) ? 2'b11 : 2'b00, tk, on, 0));
        end
`else
        for (int c = 3; c <= 5; c++) begin
            step();
            check_eq($sformatf("drop_c%0d", c), obs(), vec(2'b00, 0, 0, 0));
        end
`endif

        // 6. ignition off during right turn; invalid turn code stays idle
        _turnState = 2'b11;
        step();
        check_eq("right2_c1", obs(), vec(2'b11, 1, 1, 0));
        step();
        step();
        check_eq("right2_c3", obs(), vec(2'b11, 0, 1, 0));
        _switch = 1'b0;
        step();
        check_eq("switch_off", obs(), vec(2'b00, 0, 0, 0));
        _switch    = 1'b1;
        _turnState = 2'b10;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("invalid_c%0d", c), obs(), vec(2'b00, 0, 0, 0));
        end

        // reset mid-blink
        _hazardReq = 1'b1;
        step();
        check_eq("haz_again", obs(), vec(2'b10, 1, 1, 1));
        _reset_n = 1'b0;
        step();
        check_eq("reset_mid_blink", obs(), vec(2'b00, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
